vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Upstream stage of the pixel pipeline: generates the 640x480@60 raster scan (DrawX, DrawY, blank, hs, vs) from the pixel clock.
- The background-ROM renderer and sprite stages consume DrawX/DrawY/blank.
- Also produces copies of the sync and blank signals delayed by the downstream pixel-path latency, so they leave the chip aligned with RGB.
- Also produces frame and line event pulses plus a frame counter for animation logic.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_LAT, 2, delay of the *_d outputs in clocks (ROM read 1 + RGB register 1); 0 is legal
- FC_W, 16, frame counter width

Ports:
- vga_clk  in  1  pixel clock, 25 MHz nominal
- reset_n  in  1  reset: synchronous, active-low
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- blank  out  1  1 = visible pixel (display enable), 0 = blanked
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- line_start  out  1  one-cycle pulse when DrawX==0
- frame_start  out  1  one-cycle pulse when DrawX==0 and DrawY==0
- vblank_start  out  1  one-cycle pulse when DrawX==0 and DrawY==V_VISIBLE
- frame_cnt  out  FC_W  frames started since reset, wrapping
- blank_d  out  1  blank delayed PIPE_LAT clocks
- hs_d  out  1  hs delayed PIPE_LAT clocks
- vs_d  out  1  vs delayed PIPE_LAT clocks

Behaviour:
- Totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP = 525.
- Counters: DrawX increments every clock and wraps H_TOTAL-1 -> 0. DrawY increments only on a DrawX wrap, and wraps V_TOTAL-1 -> 0 on a simultaneous wrap. No enable input: the counters run continuously.
- Decode: all outputs are registered. Each decode is computed from the next-state counters, so in any cycle every output describes the DrawX/DrawY value presented in that same cycle (zero skew between counter and decode).
- blank = (DrawX < H_VISIBLE) && (DrawY < V_VISIBLE).
- hs = 0 iff DrawX is in [656, 751], i.e. H_VISIBLE+H_FP .. H_VISIBLE+H_FP+H_SYNC-1.
- vs = 0 iff DrawY is in [490, 491] for every pixel of those lines, independent of DrawX.
- frame_cnt increments in the same cycle frame_start is asserted; wraps modulo 2^FC_W.
- Reset (reset_n==0 sampled at a vga_clk edge) loads the last pixel of a frame:
  - DrawX=799, DrawY=524, blank=0, hs=1, vs=1
  - line_start=0, frame_start=0, vblank_start=0
  - frame_cnt = all ones
  - every delay stage: blank 0, hs 1, vs 1
- First cycle after reset release: DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1, frame_cnt=0.
- Reset mid-frame: takes effect at the next edge regardless of counter state. No partial sync pulse is extended; hs/vs return to 1 that cycle.
- Delay line: blank_d/hs_d/vs_d equal blank/hs/vs from PIPE_LAT clocks earlier. The line is a shift register, reset to the values above. PIPE_LAT=0 makes them combinational copies of the registered signals.
- Pulses are mutually consistent: frame_start implies line_start. vblank_start and frame_start are never simultaneous.
- Frame period 420000 clocks; line period 800 clocks.

Decomposition:
- Shared package vga_pkg:
  - default timing constants (H_*/V_* visible, porch and sync values, H_TOTAL, V_TOTAL)
  - coordinate width 10
  - sync polarity constant (active-low)
  - these are reused by the renderer and sprite stages
- Sub-module sync_delay_line (parameters WIDTH, DEPTH, RESET_VAL) holds the 3-bit {blank, hs, vs} shift register. Includes the DEPTH==0 pass-through generate branch.

Test Plan:
- Hold reset_n=0 for 5 clocks, then release -> during reset DrawX=799, DrawY=524, hs=vs=1, blank=0. First released cycle: DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1, frame_cnt=0.
- Run one line -> blank falls when DrawX=640. hs=0 exactly for DrawX 656..751 (96 clocks). line_start recurs every 800 clocks.
- Run one full frame -> vs=0 for DrawY 490..491 (1600 clocks). vblank_start fires once at (0,480). frame_start recurs after 420000 clocks with frame_cnt=1.
- PIPE_LAT=2 vs PIPE_LAT=0 builds -> hs_d/vs_d/blank_d are bit-identical to hs/vs/blank shifted by exactly 2 and 0 clocks respectively, checked over one frame.
- Assert reset_n=0 for 1 clock at DrawX=700, DrawY=491 (inside hs and vs) -> next cycle hs=vs=1 and DrawX=799, DrawY=524. The following cycle restarts at (0,0) with frame_cnt=0.
- FC_W=4, run 17 frames -> frame_cnt sequence 0..15 then wraps to 0 on the 17th frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared raster timing constants and sync-bit types for the pixel pipeline
// (timing generator, background renderer, sprite stages).
package vga_pkg;

   localparam int COORD_W = 10;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FP      = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BP      = 48;
   localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FP      = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BP      = 33;
   localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   // Both syncs are active-low; the idle level is what reset drives.
   localparam logic SYNC_ACTIVE = 1'b0;
   localparam logic SYNC_IDLE   = 1'b1;

   typedef struct packed {
      logic blank;
      logic hs;
      logic vs;
   } sync_bits_t;

   localparam sync_bits_t SYNC_BITS_RESET = '{blank: 1'b0, hs: SYNC_IDLE, vs: SYNC_IDLE};

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that re-times sync/blank to match the pixel-path
// latency; DEPTH==0 degenerates to a wire.
module sync_delay_line #(
   parameter int               WIDTH     = 3,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             vga_clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign o_data = i_data;
      end else begin : g_shift
         logic [WIDTH-1:0] r_stage [DEPTH];

         always_ff @(posedge vga_clk) begin
            if (!reset_n) begin
               for (int i = 0; i < DEPTH; i++) begin
                  r_stage[i] <= RESET_VAL;
               end
            end else begin
               r_stage[0] <= i_data;
               for (int i = 1; i < DEPTH; i++) begin
                  r_stage[i] <= r_stage[i-1];
               end
            end
         end

         assign o_data = r_stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: free-running pixel/line counters with registered,
// zero-skew decodes, event pulses, frame counter and latency-matched syncs.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = VGA_H_VISIBLE,
   parameter int H_FP      = VGA_H_FP,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BP      = VGA_H_BP,
   parameter int V_VISIBLE = VGA_V_VISIBLE,
   parameter int V_FP      = VGA_V_FP,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BP      = VGA_V_BP,
   parameter int PIPE_LAT  = 2,
   parameter int FC_W      = 16
) (
   input  logic               vga_clk,
   input  logic               reset_n,
   output logic [COORD_W-1:0] DrawX,
   output logic [COORD_W-1:0] DrawY,
   output logic               blank,
   output logic               hs,
   output logic               vs,
   output logic               line_start,
   output logic               frame_start,
   output logic               vblank_start,
   output logic [FC_W-1:0]    frame_cnt,
   output logic               blank_d,
   output logic               hs_d,
   output logic               vs_d
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
   localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
   localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FP);
   localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FP);
   localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FP + V_SYNC);

   logic [COORD_W-1:0] r_x, r_y;
   logic               r_blank, r_hs, r_vs;
   logic               r_line_start, r_frame_start, r_vblank_start;
   logic [FC_W-1:0]    r_frame_cnt;

   logic               w_x_wrap;
   logic [COORD_W-1:0] w_x_next, w_y_next;
   logic               w_blank_next, w_hs_next, w_vs_next;
   logic               w_line_start_next, w_frame_start_next, w_vblank_start_next;
   sync_bits_t         w_sync_d;

   // Decodes look at the next counter values so every registered output
   // lines up with the DrawX/DrawY presented in the same cycle.
   always_comb begin
      w_x_wrap = (r_x == H_LAST);
      w_x_next = w_x_wrap ? '0 : r_x + 1'b1;
      w_y_next = r_y;
      if (w_x_wrap) begin
         w_y_next = (r_y == V_LAST) ? '0 : r_y + 1'b1;
      end
      w_blank_next        = (w_x_next < H_VIS) && (w_y_next < V_VIS);
      w_hs_next           = (w_x_next >= HS_START && w_x_next < HS_END) ? SYNC_ACTIVE : SYNC_IDLE;
      w_vs_next           = (w_y_next >= VS_START && w_y_next < VS_END) ? SYNC_ACTIVE : SYNC_IDLE;
      w_line_start_next   = (w_x_next == '0);
      w_frame_start_next  = w_line_start_next && (w_y_next == '0);
      w_vblank_start_next = w_line_start_next && (w_y_next == V_VIS);
   end

   // Reset parks the scan on the last pixel so release starts a fresh frame.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         r_x            <= H_LAST;
         r_y            <= V_LAST;
         r_blank        <= 1'b0;
         r_hs           <= SYNC_IDLE;
         r_vs           <= SYNC_IDLE;
         r_line_start   <= 1'b0;
         r_frame_start  <= 1'b0;
         r_vblank_start <= 1'b0;
         r_frame_cnt    <= '1;
      end else begin
         r_x            <= w_x_next;
         r_y            <= w_y_next;
         r_blank        <= w_blank_next;
         r_hs           <= w_hs_next;
         r_vs           <= w_vs_next;
         r_line_start   <= w_line_start_next;
         r_frame_start  <= w_frame_start_next;
         r_vblank_start <= w_vblank_start_next;
         if (w_frame_start_next) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   sync_delay_line #(
      .WIDTH     (3),
      .DEPTH     (PIPE_LAT),
      .RESET_VAL (SYNC_BITS_RESET)
   ) u_sync_delay (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .i_data  ({r_blank, r_hs, r_vs}),
      .o_data  (w_sync_d)
   );

   assign DrawX        = r_x;
   assign DrawY        = r_y;
   assign blank        = r_blank;
   assign hs           = r_hs;
   assign vs           = r_vs;
   assign line_start   = r_line_start;
   assign frame_start  = r_frame_start;
   assign vblank_start = r_vblank_start;
   assign frame_cnt    = r_frame_cnt;
   assign blank_d      = w_sync_d.blank;
   assign hs_d         = w_sync_d.hs;
   assign vs_d         = w_sync_d.vs;

endmodule
